// File: rtl/imm_gen_pkg.sv
// Immediate generator shared types: format codes
// and the 5-bit major opcodes (instr[6:2]).
package imm_gen_pkg;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    I    = 3'd1,
    S    = 3'd2,
    B    = 3'd3,
    U    = 3'd4,
    J    = 3'd5,
    SH   = 3'd6
  } imm_fmt_e;

  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;

endpackage

// File: rtl/imm_gen_lane.sv
// Single-lane combinational immediate decoder:
// classifies one instruction and extends its immediate.
module imm_gen_lane
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic            lane_valid,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [4:0] op;
  logic [2:0] f3;
  logic       sx;

  assign op = instr[6:2];
  assign f3 = instr[14:12];
  assign sx = instr[31] & ~is_unsigned;

  // Fill the upper bits with the extension bit, then drop the field in.
  always_comb begin
    imm     = '0;
    fmt     = NONE;
    illegal = 1'b0;
    if (lane_valid) begin
      if (instr[1:0] != 2'b11) begin
        illegal = 1'b1;
      end else begin
        unique case (op)
          OPC_LUI, OPC_AUIPC: begin
            fmt       = U;
            imm       = {XLEN{instr[31]}};
            imm[31:0] = {instr[31:12], 12'b0};
          end
          OPC_OPIMM: begin
            if (f3 == 3'b001 || f3 == 3'b101) begin
              fmt = SH;
              if (XLEN == 64) imm[5:0] = instr[25:20];
              else imm[4:0] = instr[24:20];
            end else begin
              fmt       = I;
              imm       = {XLEN{sx}};
              imm[11:0] = instr[31:20];
            end
          end
          OPC_LOAD, OPC_JALR: begin
            fmt       = I;
            imm       = {XLEN{sx}};
            imm[11:0] = instr[31:20];
          end
          OPC_STORE: begin
            fmt       = S;
            imm       = {XLEN{sx}};
            imm[11:0] = {instr[31:25], instr[11:7]};
          end
          OPC_BRANCH: begin
            fmt       = B;
            imm       = {XLEN{sx}};
            imm[12:0] = {instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
          end
          OPC_JAL: begin
            fmt       = J;
            imm       = {XLEN{instr[31]}};
            imm[20:0] = {instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
          end
          default: illegal = 1'b1;
        endcase
      end
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Multi-lane pipelined immediate generator with valid/ready output stage.
// Define IMMGEN_SKID_EN for a one-entry skid buffer and registered in_ready.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   in_instr,
  input  logic [LANES-1:0]      in_lane_valid,
  input  logic [LANES-1:0]      in_unsigned,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*XLEN-1:0] out_imm,
  output logic [LANES*3-1:0]    out_fmt,
  output logic [LANES-1:0]      out_lane_valid,
  output logic [LANES-1:0]      out_illegal
);

  logic [LANES*XLEN-1:0] d_imm;
  logic [LANES*3-1:0]    d_fmt;
  logic [LANES-1:0]      d_ill;
  imm_fmt_e              lane_fmt [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    imm_gen_lane #(.XLEN(XLEN)) u_lane (
      .instr       (in_instr[g*32 +: 32]),
      .lane_valid  (in_lane_valid[g]),
      .is_unsigned (in_unsigned[g]),
      .imm         (d_imm[g*XLEN +: XLEN]),
      .fmt         (lane_fmt[g]),
      .illegal     (d_ill[g])
    );
    assign d_fmt[g*3 +: 3] = lane_fmt[g];
  end

  // Holds in_ready low until the first edge after reset release.
  logic run_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_q <= 1'b0;
    else     run_q <= 1'b1;
  end

  logic accept;
  assign accept = in_valid && in_ready;

`ifdef IMMGEN_SKID_EN
  logic                  skid_full;
  logic [LANES*XLEN-1:0] s_imm;
  logic [LANES*3-1:0]    s_fmt;
  logic [LANES-1:0]      s_lv;
  logic [LANES-1:0]      s_ill;
  logic                  load_out;

  assign in_ready = run_q && !flush && !skid_full;
  assign load_out = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_imm        <= '0;
      out_fmt        <= '0;
      out_lane_valid <= '0;
      out_illegal    <= '0;
      skid_full      <= 1'b0;
      s_imm          <= '0;
      s_fmt          <= '0;
      s_lv           <= '0;
      s_ill          <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (load_out) begin
      if (skid_full) begin
        out_valid      <= 1'b1;
        out_imm        <= s_imm;
        out_fmt        <= s_fmt;
        out_lane_valid <= s_lv;
        out_illegal    <= s_ill;
        skid_full      <= 1'b0;
      end else if (accept) begin
        out_valid      <= 1'b1;
        out_imm        <= d_imm;
        out_fmt        <= d_fmt;
        out_lane_valid <= in_lane_valid;
        out_illegal    <= d_ill;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      s_imm     <= d_imm;
      s_fmt     <= d_fmt;
      s_lv      <= in_lane_valid;
      s_ill     <= d_ill;
      skid_full <= 1'b1;
    end
  end
`else
  assign in_ready = run_q && !flush && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_imm        <= '0;
      out_fmt        <= '0;
      out_lane_valid <= '0;
      out_illegal    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_imm        <= d_imm;
      out_fmt        <= d_fmt;
      out_lane_valid <= in_lane_valid;
      out_illegal    <= d_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule
